// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback register file.
// Holds the GPR geometry (REG_NUM, REG_ADDR_W, REG_DATA_W), the zero word,
// the discarded-write address, and the HI/LO payload struct.
package wb_regfile_pkg;

  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef logic [REG_DATA_W-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam word_t     ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  // HI/LO pair, always written together
  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

endpackage

// File: rtl/wb_regfile_hilo.sv
// hilo_reg: HI/LO special-register pair with optional same-cycle bypass.
// Ports: clk, rst (sync, active-low), whilo (write enable), hi_i/lo_i (write
// data), hi_o/lo_o (combinational current value, forced to 0 during reset).
// Build option: WB_BYPASS_EN forwards hi_i/lo_i to the outputs while whilo=1.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  whilo,
  input  logic [REG_DATA_W-1:0] hi_i,
  input  logic [REG_DATA_W-1:0] lo_i,
  output logic [REG_DATA_W-1:0] hi_o,
  output logic [REG_DATA_W-1:0] lo_o
);

  hilo_t hilo_q;
  hilo_t hilo_d;

  // Next value: load both halves together or hold
  always_comb begin
    hilo_d = hilo_q;
    if (whilo) begin
      hilo_d.hi = hi_i;
      hilo_d.lo = lo_i;
    end
  end

  // Reset wins over a write presented in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  // Output view: zero in reset, otherwise stored (or bypassed) value
  always_comb begin
    hi_o = ZERO_WORD;
    lo_o = ZERO_WORD;
    if (rst) begin
`ifdef WB_BYPASS_EN
      if (whilo) begin
        hi_o = hi_i;
        lo_o = lo_i;
      end else begin
        hi_o = hilo_q.hi;
        lo_o = hilo_q.lo;
      end
`else
      hi_o = hilo_q.hi;
      lo_o = hilo_q.lo;
`endif
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32 x 32-bit GPR file (r0 hard-wired to 0) with two
// combinational read ports and an embedded HI/LO pair (hilo_reg).
// Ports: clk, rst (sync, active-low); we/waddr/wdata (GPR write);
// re1/raddr1/rdata1 and re2/raddr2/rdata2 (reads); whilo/hi_i/lo_i (HI/LO
// write); hi_o/lo_o (HI/LO value). All read outputs are 0 while rst=0.
// Build option: WB_BYPASS_EN forwards the in-flight write to matching reads.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [REG_DATA_W-1:0] wdata,
  input  logic                  re1,
  input  logic [REG_ADDR_W-1:0] raddr1,
  output logic [REG_DATA_W-1:0] rdata1,
  input  logic                  re2,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [REG_DATA_W-1:0] rdata2,
  input  logic                  whilo,
  input  logic [REG_DATA_W-1:0] hi_i,
  input  logic [REG_DATA_W-1:0] lo_i,
  output logic [REG_DATA_W-1:0] hi_o,
  output logic [REG_DATA_W-1:0] lo_o
);

  word_t regs_q [REG_NUM];
  word_t regs_d [REG_NUM];

  logic wr_en;
  assign wr_en = we && (waddr != NOP_REG_ADDR);

  // Next GPR state; writes to r0 are dropped so it stays zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // One read port: zero in reset, when disabled, or for r0
  function automatic word_t read_port(
    input logic      rst_n_v,
    input logic      re_v,
    input reg_addr_t ra_v,
    input logic      wr_en_v,
    input reg_addr_t wa_v,
    input word_t     wd_v,
    input word_t     stored_v
  );
    word_t r;
    r = ZERO_WORD;
    if (rst_n_v && re_v && (ra_v != NOP_REG_ADDR)) begin
`ifdef WB_BYPASS_EN
      r = (wr_en_v && (wa_v == ra_v)) ? wd_v : stored_v;
`else
      r = stored_v;
      if (wr_en_v && (wa_v == ra_v) && (wd_v == stored_v)) begin
        r = stored_v;
      end
`endif
    end
    return r;
  endfunction

  assign rdata1 = read_port(rst, re1, raddr1, wr_en, waddr, wdata, regs_q[raddr1]);
  assign rdata2 = read_port(rst, re2, raddr2, wr_en, waddr, wdata, regs_q[raddr2]);

  hilo_reg u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (whilo),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised plus directed bench for wb_regfile. A driver applies one input
// vector per cycle and queues the expected outputs from a plain array model;
// a monitor pops and compares at the falling edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        whilo;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic        wh;
    logic [31:0] h;
    logic [31:0] l;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  // Reference state: what the registers hold right now
  logic [31:0] mem [32];
  logic [31:0] m_hi, m_lo;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic stim_t st(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                               logic e1, logic [4:0] a1, logic e2, logic [4:0] a2,
                               logic wh, logic [31:0] h, logic [31:0] l);
    stim_t s;
    s.r = r; s.w = w; s.wa = wa; s.wd = wd;
    s.e1 = e1; s.a1 = a1; s.e2 = e2; s.a2 = a2;
    s.wh = wh; s.h = h; s.l = l;
    return s;
  endfunction

  function automatic logic [31:0] model_read(stim_t s, logic e, logic [4:0] a);
    if (!s.r || !e || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (s.w && s.wa == a) return s.wd;
`endif
    return mem[a];
  endfunction

  task automatic drive(input string tag, input stim_t s);
    exp_t x;
    @(posedge clk);
    #1;
    rst = s.r; we = s.w; waddr = s.wa; wdata = s.wd;
    re1 = s.e1; raddr1 = s.a1; re2 = s.e2; raddr2 = s.a2;
    whilo = s.wh; hi_i = s.h; lo_i = s.l;
    x.tag = tag;
    x.rd1 = model_read(s, s.e1, s.a1);
    x.rd2 = model_read(s, s.e2, s.a2);
    x.hi  = s.r ? m_hi : 32'd0;
    x.lo  = s.r ? m_lo : 32'd0;
`ifdef WB_BYPASS_EN
    if (s.r && s.wh) begin
      x.hi = s.h;
      x.lo = s.l;
    end
`endif
    sb.push_back(x);
    // State after the coming edge
    if (!s.r) begin
      foreach (mem[i]) mem[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      if (s.w && s.wa != 5'd0) mem[s.wa] = s.wd;
      if (s.wh) begin
        m_hi = s.h;
        m_lo = s.l;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " rdata1"}, rdata1, e.rd1);
        check({e.tag, " rdata2"}, rdata2, e.rd2);
        check({e.tag, " hi_o"},   hi_o,   e.hi);
        check({e.tag, " lo_o"},   lo_o,   e.lo);
      end
    end
  end

  initial begin
    stim_t s;
    foreach (mem[i]) mem[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    whilo = 1'b0; hi_i = '0; lo_i = '0;

    // Reset held with a write pending
    drive("rst_a", st(0, 1, 5, 32'h1234, 1, 5, 1, 5, 1, 32'hAAAA, 32'hBBBB));
    drive("rst_b", st(0, 1, 5, 32'h1234, 1, 5, 1, 5, 1, 32'hAAAA, 32'hBBBB));
    drive("post_rst", st(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));

    // Basic write then dual read of the same register
    drive("wr5", st(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
    drive("rd5_both", st(1, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0));
    drive("rd5_re2off", st(1, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0));

    // r0 write discarded
    drive("wr0", st(1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0));
    drive("rd0", st(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));

    // Same-cycle write/read of r7
    drive("wr7_rd7", st(1, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0, 0));
    drive("rd7", st(1, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));

    // HI/LO and GPR write together, then HI/LO hold
    drive("hilo_wr", st(1, 1, 3, 32'h33, 0, 0, 0, 0, 1, 32'h11111111, 32'h22222222));
    drive("hilo_hold", st(1, 0, 0, 0, 1, 3, 0, 0, 0, 32'h77777777, 32'h88888888));
    drive("hilo_chk", st(1, 0, 0, 0, 1, 3, 1, 3, 0, 32'h99999999, 32'h12121212));

    // Reset takes priority over a concurrent write
    drive("wr9", st(1, 1, 9, 32'h55, 0, 0, 0, 0, 0, 0, 0));
    drive("rd9", st(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0));
    drive("rst_wr9", st(0, 1, 9, 32'h66, 1, 9, 1, 9, 1, 32'h1, 32'h2));
    drive("rd9_after", st(1, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0));

    // Random traffic; narrow address range half the time to force collisions
    for (int i = 0; i < 400; i++) begin
      logic narrow;
      narrow = $urandom_range(1) == 1;
      s.r  = $urandom_range(31) != 0;
      s.w  = $urandom_range(3) != 0;
      s.wa = narrow ? 5'($urandom_range(3)) : 5'($urandom);
      s.wd = $urandom;
      s.e1 = $urandom_range(7) != 0;
      s.a1 = narrow ? 5'($urandom_range(3)) : 5'($urandom);
      s.e2 = $urandom_range(7) != 0;
      s.a2 = narrow ? 5'($urandom_range(3)) : 5'($urandom);
      s.wh = $urandom_range(3) == 0;
      s.h  = $urandom;
      s.l  = $urandom;
      drive("rand", s);
    end

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
